// File: rtl/input_debouncer.sv
// rtl/input_debouncer.sv - multi-channel 2-flop synchroniser and stability-count debouncer
//
// Purpose:
//   Turns raw asynchronous switch/pin levels into clean, clock-aligned levels.
//   Each channel has its own 2-flop synchroniser, a STABLE/COUNTING FSM and a
//   stability counter. A channel output follows its input only after the
//   synchronised input has differed from the output for DEBOUNCE_CYCLES
//   consecutive counted cycles; any return to the output level discards the
//   partial count.
//
// Parameters:
//   NUM_CH           number of independent channels (>= 1)
//   CNT_W            width of each per-channel stability counter
//   DEBOUNCE_CYCLES  counted stable cycles required, 1 .. 2**CNT_W-1
//
// Ports:
//   clk      in   1       rising-edge clock
//   rst      in   1       synchronous, active-high reset
//   din      in   NUM_CH  raw asynchronous inputs
//   dout     out  NUM_CH  debounced, synchronised levels
//   rise     out  NUM_CH  one-cycle pulse: dout bit just went 0->1 (DEBOUNCE_EDGE_EN only)
//   fall     out  NUM_CH  one-cycle pulse: dout bit just went 1->0 (DEBOUNCE_EDGE_EN only)
//   changed  out  1       one-cycle pulse coincident with any dout update
//   busy     out  1       high while any channel is COUNTING
//
// Optional feature macro: DEBOUNCE_EDGE_EN (adds rise/fall outputs).

module input_debouncer #(
  parameter int NUM_CH          = 2,
  parameter int CNT_W           = 4,
  parameter int DEBOUNCE_CYCLES = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] din,
  output logic [NUM_CH-1:0] dout,
`ifdef DEBOUNCE_EDGE_EN
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
`endif
  output logic              changed,
  output logic              busy
);

  // Out-of-range debounce length can never be reached by the counter (or is
  // meaningless), so refuse to elaborate.
  generate
    if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cfg
      $error("input_debouncer: DEBOUNCE_CYCLES out of range for CNT_W");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } state_t;

  // Synchroniser chain; only sync2_q is ever looked at by the FSMs.
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q   [NUM_CH];
  logic [CNT_W-1:0]  cnt_d   [NUM_CH];

  logic [NUM_CH-1:0] dout_q;
  logic [NUM_CH-1:0] dout_d;
  logic              changed_q;
  logic              changed_d;
  logic              busy_q;
  logic              busy_d;

`ifdef DEBOUNCE_EDGE_EN
  logic [NUM_CH-1:0] rise_q;
  logic [NUM_CH-1:0] rise_d;
  logic [NUM_CH-1:0] fall_q;
  logic [NUM_CH-1:0] fall_d;
`endif

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    dout_d = dout_q;
    busy_d = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        STABLE: begin
          cnt_d[i] = '0;
          if (sync2_q[i] != dout_q[i]) begin
            state_d[i] = COUNTING;
            cnt_d[i]   = CNT_ONE;
          end
        end
        COUNTING: begin
          if (sync2_q[i] == dout_q[i]) begin
            // Input bounced back: drop the partial count entirely.
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] < CNT_MAX) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
          end else begin
            // Count saturates at CNT_MAX and commits here, so it never wraps.
            dout_d[i]  = sync2_q[i];
            state_d[i] = STABLE;
            cnt_d[i]   = '0;
          end
        end
        default: begin
          state_d[i] = STABLE;
          cnt_d[i]   = '0;
        end
      endcase
      // busy is registered from the next state so it moves with the FSM.
      if (state_d[i] == COUNTING) begin
        busy_d = 1'b1;
      end
    end
    // One pulse regardless of how many channels commit on the same edge.
    changed_d = |(dout_d ^ dout_q);
  end

`ifdef DEBOUNCE_EDGE_EN
  always_comb begin
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
  end
`endif

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      dout_q    <= '0;
      changed_q <= 1'b0;
      busy_q    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= STABLE;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q   <= din;
      sync2_q   <= sync1_q;
      dout_q    <= dout_d;
      changed_q <= changed_d;
      busy_q    <= busy_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;
`endif

  assign dout    = dout_q;
  assign changed = changed_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// tb/tb_input_debouncer.sv - directed self-checking bench for input_debouncer

module tb_input_debouncer;

  logic       clk;
  logic       rst;
  logic [1:0] din;
  logic [1:0] dout;
  logic       changed;
  logic       busy;
`ifdef DEBOUNCE_EDGE_EN
  logic [1:0] rise;
  logic [1:0] fall;
`endif

  int total;
  int bad;

  input_debouncer #(
    .NUM_CH(2),
    .CNT_W(4),
    .DEBOUNCE_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .din(din),
    .dout(dout),
`ifdef DEBOUNCE_EDGE_EN
    .rise(rise),
    .fall(fall),
`endif
    .changed(changed),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // din has just been changed; tick 1 is E0, the update lands on tick 13
  // (E0+12). busy is high on ticks 3..12 when the step is clean.
  task automatic watch(input string tag, input logic [1:0] old_v, input logic [1:0] new_v,
                       input logic chk_busy, input logic [1:0] rise_exp,
                       input logic [1:0] fall_exp);
    for (int k = 1; k <= 13; k++) begin
      tick();
      check({tag, "_dout"}, 8'(dout), 8'((k == 13) ? new_v : old_v));
      check({tag, "_changed"}, 8'(changed), 8'(k == 13));
      if (chk_busy) check({tag, "_busy"}, 8'(busy), 8'(k >= 3 && k <= 12));
`ifdef DEBOUNCE_EDGE_EN
      check({tag, "_rise"}, 8'(rise), 8'((k == 13) ? rise_exp : 2'b00));
      check({tag, "_fall"}, 8'(fall), 8'((k == 13) ? fall_exp : 2'b00));
`endif
    end
    tick();
    check({tag, "_hold"}, 8'(dout), 8'(new_v));
    check({tag, "_pulse_end"}, 8'(changed), 8'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    din   = 2'b11;

    // Reset held for 3 edges with din=11.
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_dout", 8'(dout), 8'h0);
      check("rst_changed", 8'(changed), 8'h0);
      check("rst_busy", 8'(busy), 8'h0);
    end
    rst = 1'b0;
    watch("rst_release", 2'b00, 2'b11, 1'b1, 2'b11, 2'b00);

    // Back to a clean zero state.
    rst = 1'b1;
    din = 2'b00;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("idle_dout", 8'(dout), 8'h0);
    check("idle_busy", 8'(busy), 8'h0);

    // Clean step on channel 0, held 20 cycles total.
    din = 2'b01;
    watch("step", 2'b00, 2'b01, 1'b1, 2'b01, 2'b00);
    for (int k = 0; k < 6; k++) tick();
    check("step_settled", 8'(dout), 8'h1);

    // Glitch on channel 1: high for exactly 10 sampling edges.
    din = 2'b11;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("glitch_dout_a", 8'(dout), 8'h1);
      check("glitch_chg_a", 8'(changed), 8'h0);
    end
    din = 2'b01;
    for (int k = 0; k < 20; k++) begin
      tick();
      check("glitch_dout_b", 8'(dout), 8'h1);
      check("glitch_chg_b", 8'(changed), 8'h0);
    end
    check("glitch_busy", 8'(busy), 8'h0);

    // Clear channel 0 (fall on ch0).
    din = 2'b00;
    watch("clr0", 2'b01, 2'b00, 1'b1, 2'b00, 2'b01);

    // Bounce 1,0,1,0 then settle at 1.
    din = 2'b01; tick();
    din = 2'b00; tick();
    din = 2'b01; tick();
    din = 2'b00; tick();
    din = 2'b01;
    watch("bounce", 2'b00, 2'b01, 1'b0, 2'b01, 2'b00);
    check("bounce_busy", 8'(busy), 8'h0);

    // Return to 00, then both channels together.
    din = 2'b00;
    watch("clr1", 2'b01, 2'b00, 1'b1, 2'b00, 2'b01);
    din = 2'b11;
    watch("simul", 2'b00, 2'b11, 1'b1, 2'b11, 2'b00);
    din = 2'b10;
    watch("ch0_fall", 2'b11, 2'b10, 1'b1, 2'b00, 2'b01);

    // Reset in the middle of a 0->1 count on channel 0 (count 5 after E6).
    din = 2'b11;
    for (int k = 0; k < 7; k++) tick();
    check("midrst_busy_before", 8'(busy), 8'h1);
    check("midrst_dout_before", 8'(dout), 8'h2);
    rst = 1'b1;
    tick();
    check("midrst_dout", 8'(dout), 8'h0);
    check("midrst_busy", 8'(busy), 8'h0);
    check("midrst_changed", 8'(changed), 8'h0);
    rst = 1'b0;
    watch("midrst_release", 2'b00, 2'b11, 1'b1, 2'b11, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute backstop so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
